// File: rtl/ps2_lcd_text_buffer.sv
// Keystroke-to-LCD text engine: runs LCD init, buffers PS2 make codes (with backspace), flushes on full/Enter.
// One LCD start/done handshake per word; keys arriving while not idle are dropped and flagged on drop_pulse.
module ps2_lcd_text_buffer #(
  parameter int         DEPTH          = 16,
  parameter int         CHARS_PER_LINE = 16,
  parameter int         NUM_LINES      = 2,
  parameter bit         FLUSH_ON_ENTER = 1'b1,
  parameter logic [7:0] ENTER_CODE     = 8'h5A,
  parameter logic [7:0] BKSP_CODE      = 8'h66
) (
  input  logic                       CLOCK_50_I,
  input  logic                       resetn,
  input  logic [7:0]                 ps2_code,
  input  logic                       ps2_code_ready,
  input  logic                       ps2_make_code,
  output logic [8:0]                 rom_address,
  input  logic [7:0]                 rom_q,
  output logic                       lcd_start,
  output logic [8:0]                 lcd_instruction,
  input  logic                       lcd_done,
  output logic [$clog2(DEPTH+1)-1:0] char_count,
  output logic                       busy,
  output logic                       drop_pulse
);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int IW   = $clog2(DEPTH);
  localparam int COLW = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;

  typedef enum logic [2:0] {
    S_INIT, S_INIT_WAIT, S_IDLE, S_ROM_WAIT,
    S_ISSUE, S_FINISH, S_ISSUE_LINE, S_FINISH_LINE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_buf [DEPTH];
  logic [CW-1:0]   r_char_count;
  logic [IW-1:0]   r_rd_idx;
  logic [2:0]      r_init_idx;
  logic [COLW-1:0] r_col;
  logic [1:0]      r_line;
  logic            r_rdy_d;
  logic            r_lcd_start;
  logic            r_drop;
  logic [8:0]      r_lcd_instr;

  logic            w_evt, w_done, w_is_bksp, w_is_enter, w_has_chars;
  logic            w_more, w_col_wrap, w_last_init, w_full_next;
  logic [1:0]      w_line_nxt;
  logic [6:0]      w_line_base;
  logic [8:0]      w_init_word;

  assign w_evt       = ps2_code_ready & ~r_rdy_d & ps2_make_code;
  // the controller may still be reporting the previous command while start is high
  assign w_done      = lcd_done & ~r_lcd_start;
  assign w_is_bksp   = (ps2_code == BKSP_CODE);
  assign w_is_enter  = FLUSH_ON_ENTER && (ps2_code == ENTER_CODE);
  assign w_has_chars = (r_char_count != '0);
  assign w_full_next = (r_char_count == CW'(DEPTH - 1));
  assign w_more      = (CW'(r_rd_idx) + CW'(1)) < r_char_count;
  assign w_col_wrap  = (r_col == COLW'(CHARS_PER_LINE - 1));
  assign w_last_init = (r_init_idx == 3'd4);
  assign w_line_nxt  = (r_line == 2'(NUM_LINES - 1)) ? 2'd0 : r_line + 2'd1;

  always_comb begin
    case (r_line)
      2'd0:    w_line_base = 7'h00;
      2'd1:    w_line_base = 7'h40;
      2'd2:    w_line_base = 7'h14;
      default: w_line_base = 7'h54;
    endcase
    case (r_init_idx)
      3'd0:    w_init_word = 9'h038;
      3'd1:    w_init_word = 9'h00C;
      3'd2:    w_init_word = 9'h001;
      3'd3:    w_init_word = 9'h006;
      default: w_init_word = 9'h080;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) r_state <= S_INIT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:      w_state_nxt = S_INIT_WAIT;
      S_INIT_WAIT: if (w_done) w_state_nxt = w_last_init ? S_IDLE : S_INIT;
      S_IDLE: begin
        if (w_evt && !w_is_bksp) begin
          if (w_is_enter) begin
            if (w_has_chars) w_state_nxt = S_ROM_WAIT;
          end else if (w_full_next) begin
            w_state_nxt = S_ROM_WAIT;
          end
        end
      end
      S_ROM_WAIT:   w_state_nxt = S_ISSUE;
      S_ISSUE:      w_state_nxt = S_FINISH;
      S_FINISH: begin
        if (w_done) begin
          if (w_col_wrap) w_state_nxt = S_ISSUE_LINE;
          else            w_state_nxt = w_more ? S_ROM_WAIT : S_IDLE;
        end
      end
      S_ISSUE_LINE:  w_state_nxt = S_FINISH_LINE;
      S_FINISH_LINE: if (w_done) w_state_nxt = w_more ? S_ROM_WAIT : S_IDLE;
      default:       w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_rdy_d      <= 1'b0;
      r_lcd_start  <= 1'b0;
      r_lcd_instr  <= 9'h000;
      r_drop       <= 1'b0;
      r_init_idx   <= 3'd0;
      r_char_count <= '0;
      r_rd_idx     <= '0;
      r_col        <= '0;
      r_line       <= 2'd0;
    end else begin
      r_rdy_d     <= ps2_code_ready;
      r_lcd_start <= 1'b0;
      r_drop      <= w_evt && (r_state != S_IDLE);
      case (r_state)
        S_INIT: begin
          r_lcd_instr <= w_init_word;
          r_lcd_start <= 1'b1;
        end
        S_INIT_WAIT: if (w_done) r_init_idx <= r_init_idx + 3'd1;
        S_IDLE: begin
          if (w_evt) begin
            if (w_is_bksp) begin
              if (w_has_chars) r_char_count <= r_char_count - CW'(1);
            end else if (w_is_enter) begin
              if (w_has_chars) r_rd_idx <= '0;
            end else begin
              r_char_count <= r_char_count + CW'(1);
              if (w_full_next) r_rd_idx <= '0;
            end
          end
        end
        S_ISSUE: begin
          r_lcd_instr <= {1'b1, rom_q};
          r_lcd_start <= 1'b1;
        end
        S_FINISH: begin
          if (w_done) begin
            // on a wrap the read index advances after the line address has been sent
            if (w_col_wrap) begin
              r_col  <= '0;
              r_line <= w_line_nxt;
            end else begin
              r_col <= r_col + COLW'(1);
              if (w_more) r_rd_idx     <= r_rd_idx + IW'(1);
              else        r_char_count <= '0;
            end
          end
        end
        S_ISSUE_LINE: begin
          r_lcd_instr <= {2'b01, w_line_base};
          r_lcd_start <= 1'b1;
        end
        S_FINISH_LINE: begin
          if (w_done) begin
            if (w_more) r_rd_idx     <= r_rd_idx + IW'(1);
            else        r_char_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= 8'h00;
    end else if (r_state == S_IDLE && w_evt && !w_is_bksp && !w_is_enter) begin
      r_buf[r_char_count[IW-1:0]] <= ps2_code;
    end
  end

  assign rom_address     = {1'b0, r_buf[r_rd_idx]};
  assign lcd_start       = r_lcd_start;
  assign lcd_instruction = r_lcd_instr;
  assign char_count      = r_char_count;
  assign busy            = (r_state != S_IDLE);
  assign drop_pulse      = r_drop;
endmodule

// File: tb/tb_ps2_lcd_text_buffer.sv
// Bench for ps2_lcd_text_buffer: LCD and ROM models plus an instruction scoreboard.
`timescale 1ns/1ps
module tb_ps2_lcd_text_buffer;
  logic       CLOCK_50_I = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_code = 8'h00;
  logic       ps2_code_ready = 1'b0;
  logic       ps2_make_code = 1'b0;
  logic [8:0] rom_address;
  logic [7:0] rom_q = 8'h00;
  logic       lcd_start;
  logic [8:0] lcd_instruction;
  logic       lcd_done = 1'b0;
  logic [4:0] char_count;
  logic       busy;
  logic       drop_pulse;

  int n_checks = 0;
  int n_pass = 0;
  int dbl_cnt = 0;
  int drop_cnt = 0;
  int done_cnt = 0;
  bit prev_start = 1'b0;
  bit last_drop = 1'b0;
  int cur_col = 0;
  int cur_line = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  ps2_lcd_text_buffer dut (
    .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .ps2_code(ps2_code),
    .ps2_code_ready(ps2_code_ready), .ps2_make_code(ps2_make_code),
    .rom_address(rom_address), .rom_q(rom_q), .lcd_start(lcd_start),
    .lcd_instruction(lcd_instruction), .lcd_done(lcd_done),
    .char_count(char_count), .busy(busy), .drop_pulse(drop_pulse)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  function automatic logic [7:0] rom_f(input logic [7:0] c);
    return c ^ 8'hC3;
  endfunction

  always @(posedge CLOCK_50_I) rom_q <= rom_f(rom_address[7:0]);

  // LCD model: records each started instruction, answers with a 1-cycle done 10 cycles later
  always @(negedge CLOCK_50_I) begin
    lcd_done = 1'b0;
    if (!resetn) begin
      done_cnt = 0;
      prev_start = 1'b0;
    end else begin
      if (lcd_start) begin
        if (prev_start) dbl_cnt++;
        obs_q.push_back(lcd_instruction);
        done_cnt = 10;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) lcd_done = 1'b1;
      end
      prev_start = lcd_start;
      if (drop_pulse) drop_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] line_base(input int l);
    case (l)
      0:       return 7'h00;
      1:       return 7'h40;
      2:       return 7'h14;
      default: return 7'h54;
    endcase
  endfunction

  task automatic expect_char(input logic [7:0] code);
    exp_q.push_back({1'b1, rom_f(code)});
    if (cur_col == 15) begin
      cur_col = 0;
      cur_line = (cur_line + 1) % 2;
      exp_q.push_back({2'b01, line_base(cur_line)});
    end else begin
      cur_col++;
    end
  endtask

  task automatic press(input logic [7:0] code, input logic make);
    @(negedge CLOCK_50_I);
    ps2_code = code;
    ps2_make_code = make;
    ps2_code_ready = 1'b1;
    @(negedge CLOCK_50_I);
    ps2_code_ready = 1'b0;
    last_drop = drop_pulse;
    @(negedge CLOCK_50_I);
  endtask

  task automatic wait_flush(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge CLOCK_50_I); #2;
      if (obs_q.size() >= n && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    logic [8:0] got, exp;
    resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50_I);
    n_checks++; if (lcd_start !== 1'b0) $display("FAIL rst_start: got %b want 0", lcd_start); else n_pass++;
    n_checks++; if (lcd_instruction !== 9'h000) $display("FAIL rst_instr: got %h want 000", lcd_instruction); else n_pass++;
    n_checks++; if (char_count !== 5'd0) $display("FAIL rst_count: got %0d want 0", char_count); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if (drop_pulse !== 1'b0) $display("FAIL rst_drop: got %b want 0", drop_pulse); else n_pass++;
    n_checks++; if (rom_address !== 9'h000) $display("FAIL rst_rom_addr: got %h want 000", rom_address); else n_pass++;
    exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    resetn = 1'b1;
    wait_flush(5, ok);
    n_checks++; if (!ok) $display("FAIL init_timeout: got %0d instrs, busy %b want 5 and idle", obs_q.size(), busy); else n_pass++;
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL init_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL init_word: got %h want %h", got, exp); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_full_flush();
    bit ok;
    logic [8:0] got, exp;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        logic [7:0] c;
        c = 8'h10 + 8'(16 * f + i);
        expect_char(c);
        press(c, 1'b1);
      end
      n_checks++; if (char_count !== 5'd16) $display("FAIL full_count: got %0d want 16", char_count); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL full_autostart: got busy %b want 1", busy); else n_pass++;
      wait_flush(17, ok);
      n_checks++; if (!ok) $display("FAIL full_timeout: got %0d instrs want 17", obs_q.size()); else n_pass++;
      n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL full_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        got = obs_q.pop_front(); exp = exp_q.pop_front();
        n_checks++; if (got !== exp) $display("FAIL full_instr: got %h want %h", got, exp); else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
      n_checks++; if (char_count !== 5'd0) $display("FAIL full_cleared: got %0d want 0", char_count); else n_pass++;
    end
  endtask

  task automatic test_enter_flush();
    bit ok;
    logic [8:0] got, exp;
    logic [7:0] codes [3] = '{8'h1C, 8'h32, 8'h21};
    foreach (codes[i]) begin
      expect_char(codes[i]);
      press(codes[i], 1'b1);
    end
    n_checks++; if (char_count !== 5'd3) $display("FAIL enter_count: got %0d want 3", char_count); else n_pass++;
    press(8'h5A, 1'b1);
    wait_flush(3, ok);
    n_checks++; if (!ok) $display("FAIL enter_timeout: got %0d instrs want 3", obs_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL enter_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL enter_instr: got %h want %h", got, exp); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    n_checks++; if (char_count !== 5'd0) $display("FAIL enter_cleared: got %0d want 0", char_count); else n_pass++;
  endtask

  task automatic test_backspace();
    bit ok;
    int d0;
    logic [8:0] got, exp;
    press(8'h1C, 1'b1);
    press(8'h32, 1'b1);
    press(8'h66, 1'b1);
    n_checks++; if (char_count !== 5'd1) $display("FAIL bksp_count: got %0d want 1", char_count); else n_pass++;
    expect_char(8'h1C);
    press(8'h5A, 1'b1);
    wait_flush(1, ok);
    n_checks++; if (!ok) $display("FAIL bksp_timeout: got %0d instrs want 1", obs_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL bksp_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL bksp_instr: got %h want %h", got, exp); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    d0 = drop_cnt;
    press(8'h66, 1'b1);
    press(8'h5A, 1'b1);
    repeat (3) @(negedge CLOCK_50_I);
    n_checks++; if (char_count !== 5'd0) $display("FAIL bksp_empty_count: got %0d want 0", char_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL empty_enter_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (obs_q.size() !== 0) $display("FAIL empty_enter_writes: got %0d want 0", obs_q.size()); else n_pass++;
    n_checks++; if (drop_cnt !== d0) $display("FAIL bksp_empty_drop: got %0d want %0d", drop_cnt, d0); else n_pass++;
  endtask

  task automatic test_drop();
    bit ok;
    int d0;
    logic [8:0] got, exp;
    logic [7:0] codes [3] = '{8'h15, 8'h1D, 8'h24};
    foreach (codes[i]) begin
      expect_char(codes[i]);
      press(codes[i], 1'b1);
    end
    press(8'h5A, 1'b1);
    d0 = drop_cnt;
    press(8'h2D, 1'b1);
    n_checks++; if (last_drop !== 1'b1) $display("FAIL drop_pulse: got %b want 1", last_drop); else n_pass++;
    n_checks++; if (char_count !== 5'd3) $display("FAIL drop_count: got %0d want 3", char_count); else n_pass++;
    press(8'h2D, 1'b0);
    n_checks++; if (last_drop !== 1'b0) $display("FAIL break_busy_drop: got %b want 0", last_drop); else n_pass++;
    n_checks++; if (drop_cnt !== d0 + 1) $display("FAIL drop_width: got %0d want %0d", drop_cnt, d0 + 1); else n_pass++;
    wait_flush(3, ok);
    n_checks++; if (!ok) $display("FAIL drop_timeout: got %0d instrs want 3", obs_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL drop_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL drop_instr: got %h want %h", got, exp); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    d0 = drop_cnt;
    press(8'h1C, 1'b0);
    n_checks++; if (char_count !== 5'd0) $display("FAIL break_idle_count: got %0d want 0", char_count); else n_pass++;
    n_checks++; if (drop_cnt !== d0) $display("FAIL break_idle_drop: got %0d want %0d", drop_cnt, d0); else n_pass++;
  endtask

  task automatic test_reset_mid_flush();
    bit ok;
    logic [8:0] got, exp;
    for (int i = 0; i < 16; i++) press(8'h40 + 8'(i), 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge CLOCK_50_I); #2;
      if (obs_q.size() >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) $display("FAIL midrst_reach: got %0d writes want 5", obs_q.size()); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++; if (lcd_start !== 1'b0) $display("FAIL midrst_start: got %b want 0", lcd_start); else n_pass++;
    n_checks++; if (lcd_instruction !== 9'h000) $display("FAIL midrst_instr: got %h want 000", lcd_instruction); else n_pass++;
    n_checks++; if (char_count !== 5'd0) $display("FAIL midrst_count: got %0d want 0", char_count); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL midrst_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if (rom_address !== 9'h000) $display("FAIL midrst_rom_addr: got %h want 000", rom_address); else n_pass++;
    exp_q.delete(); obs_q.delete();
    cur_col = 0;
    cur_line = 0;
    repeat (3) @(negedge CLOCK_50_I);
    exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    resetn = 1'b1;
    wait_flush(5, ok);
    n_checks++; if (!ok) $display("FAIL reinit_timeout: got %0d instrs want 5", obs_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL reinit_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL reinit_word: got %h want %h", got, exp); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    n_checks++; if (char_count !== 5'd0) $display("FAIL reinit_count: got %0d want 0", char_count); else n_pass++;
    expect_char(8'h1C);
    press(8'h1C, 1'b1);
    press(8'h5A, 1'b1);
    wait_flush(1, ok);
    n_checks++; if (!ok) $display("FAIL post_rst_timeout: got %0d instrs want 1", obs_q.size()); else n_pass++;
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL post_rst_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL post_rst_instr: got %h want %h", got, exp); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_flush();
    test_enter_flush();
    test_backspace();
    test_drop();
    test_reset_mid_flush();
    n_checks++; if (dbl_cnt !== 0) $display("FAIL start_width: got %0d long pulses want 0", dbl_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
